div_share_ctrl: RTL and testbench
=================================

Name: div_share_ctrl

Overview:
- Sequences one shared multi-cycle signed divider core between two requesters (e.g. the ALU path and the debug/console path).
- Arbitrates round-robin and latches the granted operands.
- Bypasses the core for divide-by-zero and signed overflow.
- Launches the core with a one-cycle start pulse, watches for completion with a timeout, and returns tagged results over a valid/ready response per requester.

Parameters:
- W, 32, operand/result width in bits (two's-complement signed).
- TIMEOUT_CYC, 40, max cycles in WAIT before forced abort; must exceed the core latency (W+2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  2  per-requester request valid.
- req_x0, req_y0  in  W each  requester 0 dividend, divisor.
- req_x1, req_y1  in  W each  requester 1 dividend, divisor.
- req_ready  out  2  per-requester accept; at most one bit high.
- rsp_valid  out  2  per-requester response valid; at most one bit high.
- rsp_ready  in  2  per-requester response accept.
- rsp_q  out  W  quotient, truncated toward zero.
- rsp_r  out  W  remainder, sign follows dividend.
- rsp_err  out  2  00 ok, 01 div-by-zero, 10 overflow, 11 timeout.
- busy  out  1  high whenever state is not IDLE.
- div_start  out  1  one-cycle launch pulse to the core.
- div_x, div_y  out  W each  latched operands; stable from ISSUE until WAIT exits.
- div_done  in  1  one-cycle core completion pulse.
- div_q, div_r  in  W each  core results, valid while div_done=1.

Behaviour:
- Reset: state=IDLE; last_grant=1, so requester 0 wins the first tie.
- Reset values: req_ready, rsp_valid, div_start, busy all 0; rsp_q, rsp_r, div_x, div_y, rsp_err all 0; timeout counter 0.
- Reset mid-operation aborts everything with no response. A div_done arriving after reset is ignored.
- States are IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - req_ready is combinational: high only for the granted requester, only in IDLE.
  - With one request pending, that requester wins.
  - With both pending, the requester not equal to last_grant wins.
- IDLE, on handshake (req_valid & req_ready):
  - Latch x, y and the grant index into g.
  - If y==0: rsp_q=all-ones, rsp_r=x, rsp_err=01, go to RESP.
  - Else if x==most-negative and y==-1: rsp_q=x, rsp_r=0, rsp_err=10, go to RESP.
  - Otherwise go to ISSUE.
- ISSUE: div_start=1 for exactly one cycle; clear the counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On div_done: latch div_q/div_r into rsp_q/rsp_r, rsp_err=00, go to RESP.
  - If the counter reaches TIMEOUT_CYC-1 without div_done: rsp_q=0, rsp_r=0, rsp_err=11, go to RESP.
  - If div_done and the timeout coincide, div_done wins.
- RESP:
  - rsp_valid[g]=1; rsp_q, rsp_r, rsp_err are held stable.
  - On rsp_ready[g]: last_grant=g, go to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- Latency, normal path, measured from the accept edge (cycle 0): div_start in cycle 1; core done in cycle 1+L; rsp_valid from cycle 2+L.
- Latency, bypass path: rsp_valid in cycle 1.
- No new request is accepted until the response handshake completes. Back-to-back use: the response handshake in cycle n allows an accept in cycle n+1.
- A requester dropping req_valid before its grant is legal; it simply loses arbitration.

Decomposition:
- Package div_ctrl_pkg holds:
  - state enum: IDLE, ISSUE, WAIT, RESP.
  - error-code constants: ERR_OK, ERR_DIV0, ERR_OVF, ERR_TIMEOUT.
  - function is_ovf(x, y).
- Sub-module rr_arb2 is the two-way round-robin grant logic. Inputs: req[1:0], last_grant. Output: one-hot gnt[1:0].
- The bench pairs the controller with the shared divider core and a stub core with programmable latency/hang.

Test Plan:
- Single request: req0 x=100, y=7 -> one div_start pulse; rsp_valid[0] with q=14, r=2, err=00, exactly 2+L cycles after accept.
- Signed operands: req1 x=-100, y=7 -> q=-14 (0xFFFFFFF2), r=-2 (0xFFFFFFFE), err=00.
- Contention: both valid at reset exit -> req0 served first, then req1; both requests held again -> grants alternate 0, 1, 0, 1.
- Bypasses, with div_start never asserted and rsp_valid 1 cycle after accept:
  - y=0, x=5 -> q=0xFFFFFFFF, r=5, err=01.
  - x=0x80000000, y=-1 -> q=0x80000000, r=0, err=10.
- Timeout: stub core never raises div_done -> rsp_err=11, q=r=0 after TIMEOUT_CYC cycles in WAIT; a late div_done is ignored and the next request proceeds normally.
- Backpressure and reset:
  - rsp_ready held low for 10 cycles -> rsp_valid and data stay stable, no new req_ready.
  - rst asserted in WAIT -> all outputs 0 and no stale response after release.

Source files
------------

// File: rtl/div_share_ctrl_pkg.sv
// Shared types and helpers for the divider-sharing controller.
// Contents: FSM state enum, response error codes, and the signed-overflow
// detector used to bypass the core for MIN / -1.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_OVF     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Widest operand the overflow helper handles.
  localparam int MAXW = 64;

  // True when the w-bit operands are x == most-negative and y == -1.
  // Callers pass their operands zero-extended to MAXW bits.
  function automatic logic is_ovf(input logic [MAXW-1:0] x,
                                  input logic [MAXW-1:0] y,
                                  input int              w);
    logic [MAXW-1:0] mask;
    logic [MAXW-1:0] msb;
    mask = (w >= MAXW) ? '1 : ((64'd1 << w) - 64'd1);
    msb  = 64'd1 << (w - 1);
    return ((x & mask) == msb) && ((y & mask) == mask);
  endfunction

endpackage

// File: rtl/div_share_ctrl_rr_arb2.sv
// Two-way round-robin grant logic (purely combinational).
// Ports: req_i - pending requests; last_grant_i - index served last;
//        gnt_o - one-hot grant, the requester not served last wins a tie.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Sequences one shared multi-cycle signed divider between two requesters.
// Ports: req_* - per-requester operands and valid/ready accept;
//        rsp_*  - tagged response (q, r, err) with per-requester valid/ready;
//        div_*  - core launch pulse, latched operands, completion and results.
import div_ctrl_pkg::*;

module div_share_ctrl #(
  parameter int W           = 32,
  parameter int TIMEOUT_CYC = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  input  logic [W-1:0] req_x0,
  input  logic [W-1:0] req_y0,
  input  logic [W-1:0] req_x1,
  input  logic [W-1:0] req_y1,
  output logic [1:0]   req_ready,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [W-1:0] rsp_q,
  output logic [W-1:0] rsp_r,
  output logic [1:0]   rsp_err,
  output logic         busy,
  output logic         div_start,
  output logic [W-1:0] div_x,
  output logic [W-1:0] div_y,
  input  logic         div_done,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t         state_q;
  logic           g_q;
  logic           last_grant_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   x_q, y_q;
  logic [W-1:0]   quo_q, rem_q;
  logic [1:0]     err_q;

  logic [1:0]     gnt;
  logic [1:0]     hs;
  logic [W-1:0]   sel_x, sel_y;

  rr_arb2 u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  // Gated by rst so nothing is offered while reset is held.
  assign req_ready = (state_q == IDLE && !rst) ? gnt : 2'b00;
  assign hs        = req_valid & req_ready;
  assign sel_x     = hs[1] ? req_x1 : req_x0;
  assign sel_y     = hs[1] ? req_y1 : req_y0;

  assign rsp_valid = (state_q == RESP) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state_q != IDLE);
  assign div_start = (state_q == ISSUE);
  assign div_x     = x_q;
  assign div_y     = y_q;
  assign rsp_q     = quo_q;
  assign rsp_r     = rem_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      g_q          <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      err_q        <= ERR_OK;
    end else begin
      case (state_q)
        IDLE: begin
          if (|hs) begin
            x_q <= sel_x;
            y_q <= sel_y;
            g_q <= hs[1];
            if (sel_y == '0) begin
              quo_q   <= '1;
              rem_q   <= sel_x;
              err_q   <= ERR_DIV0;
              state_q <= RESP;
            end else if (is_ovf(MAXW'(sel_x), MAXW'(sel_y), W)) begin
              quo_q   <= sel_x;
              rem_q   <= '0;
              err_q   <= ERR_OVF;
              state_q <= RESP;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Completion takes priority over a coinciding timeout.
          if (div_done) begin
            quo_q   <= div_q;
            rem_q   <= div_r;
            err_q   <= ERR_OK;
            state_q <= RESP;
          end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            quo_q   <= '0;
            rem_q   <= '0;
            err_q   <= ERR_TIMEOUT;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready[g_q]) begin
            last_grant_q <= g_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
module tb_div_share_ctrl;

  localparam int W      = 32;
  localparam int TO     = 40;
  localparam int CORE_L = W + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   rsp_ready = 2'b00;
  logic [W-1:0] req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
  logic [1:0]   req_ready, rsp_valid, rsp_err;
  logic [W-1:0] rsp_q, rsp_r, div_x, div_y;
  logic         busy, div_start;

  logic         core_done;
  logic         inj_done = 1'b0;
  logic         hang = 1'b0;
  logic [W-1:0] core_q, core_r;
  int           rem_cnt;
  logic         div_done;

  int checks = 0;
  int errors = 0;
  int last_grant_m = 1;

  assign div_done = core_done | inj_done;

  always #5 clk = ~clk;

  div_share_ctrl #(.W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
    .busy(busy), .div_start(div_start),
    .div_x(div_x), .div_y(div_y),
    .div_done(div_done), .div_q(core_q), .div_r(core_r)
  );

  // Divider core stand-in: fixed latency CORE_L, or never finishes when hang=1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_cnt   <= 0;
      core_done <= 1'b0;
      core_q    <= '0;
      core_r    <= '0;
    end else begin
      core_done <= 1'b0;
      if (div_start && !hang) begin
        rem_cnt <= CORE_L - 1;
        core_q  <= W'($signed(div_x) / $signed(div_y));
        core_r  <= W'($signed(div_x) % $signed(div_y));
      end else if (rem_cnt > 0) begin
        rem_cnt   <= rem_cnt - 1;
        core_done <= (rem_cnt == 1);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: what a signed divider with the bypass rules must return.
  function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic [1:0] e);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sy == 0) begin
      q = '1; r = x; e = 2'd1;
    end else if (sx == -(longint'(1) << (W - 1)) && sy == -1) begin
      q = x; r = '0; e = 2'd2;
    end else begin
      q = W'(sx / sy); r = W'(sx % sy); e = 2'd0;
    end
  endfunction

  // One full transaction: offer vld, check grant, latency, result, backpressure.
  task automatic txn(input logic [1:0] vld, input logic [W-1:0] x0, input logic [W-1:0] y0,
                     input logic [W-1:0] x1, input logic [W-1:0] y1,
                     input int hold, input bit timeout);
    logic [1:0]   exp_gnt, exp_v;
    logic [W-1:0] x, y, eq, er;
    logic [1:0]   ee;
    int           g, n, n_exp, starts;
    bit           quiet, held;
    req_x0 = x0; req_y0 = y0; req_x1 = x1; req_y1 = y1;
    req_valid = vld;
    #1;
    exp_gnt = (vld == 2'b11) ? ((last_grant_m == 1) ? 2'b01 : 2'b10) : vld;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      tick;
      n++;
    end
    chk("grant", 64'(req_ready), 64'(exp_gnt));
    if (req_ready == 2'b00) begin
      req_valid = 2'b00;
      return;
    end
    g = req_ready[1] ? 1 : 0;
    x = g ? x1 : x0;
    y = g ? y1 : y0;
    ref_div(x, y, eq, er, ee);
    if (timeout) begin
      eq = '0; er = '0; ee = 2'd3;
    end
    n_exp = (ee == 2'd1 || ee == 2'd2) ? 0 : (timeout ? TO + 1 : CORE_L + 1);
    exp_v = g ? 2'b10 : 2'b01;
    tick;
    req_valid[g] = 1'b0;
    n = 0; starts = 0; quiet = 1'b1;
    while (rsp_valid == 2'b00 && n < 100) begin
      if (div_start) starts++;
      if (req_ready != 2'b00) quiet = 1'b0;
      if (div_x !== x || div_y !== y) quiet = 1'b0;
      tick;
      n++;
    end
    chk("latency", 64'(n), 64'(n_exp));
    chk("starts", 64'(starts), 64'((n_exp == 0) ? 0 : 1));
    chk("busy_quiet", 64'(quiet), 64'(1));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
    chk("rsp_q", 64'(rsp_q), 64'(eq));
    chk("rsp_r", 64'(rsp_r), 64'(er));
    chk("rsp_err", 64'(rsp_err), 64'(ee));
    held = 1'b1;
    for (int i = 0; i < hold; i++) begin
      rsp_ready = g ? 2'b01 : 2'b10;  // wrong requester's ready must be ignored
      tick;
      if (rsp_valid !== exp_v || rsp_q !== eq || rsp_r !== er ||
          rsp_err !== ee || req_ready !== 2'b00) held = 1'b0;
    end
    if (hold > 0) chk("hold_stable", 64'(held), 64'(1));
    rsp_ready = exp_v;
    tick;
    rsp_ready = 2'b00;
    chk("rsp_release", 64'({busy, rsp_valid}), 64'(0));
    last_grant_m = g;
  endtask

  logic [W-1:0] rx0, ry0, rx1, ry1;
  bit           idle_ok;

  initial begin
    // Reset with both requesters already pending.
    req_valid = 2'b11;
    req_x0 = 32'd100; req_y0 = 32'd7; req_x1 = -32'sd100; req_y1 = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_ctrl", 64'({rsp_valid, div_start, busy, rsp_err}), 64'(0));
    chk("rst_data", {rsp_q, rsp_r}, 64'(0));
    chk("rst_ops", {div_x, div_y}, 64'(0));
    rst = 1'b0;

    // Contention at reset exit: req0 then req1 (also the signed case).
    txn(2'b11, 32'd100, 32'd7, -32'sd100, 32'd7, 0, 1'b0);
    txn(2'b11, 32'd100, 32'd7, -32'sd100, 32'd7, 0, 1'b0);
    // Alternation continues with fresh operands; backpressure on a core result.
    txn(2'b11, 32'd1234567, 32'd89, -32'sd77, -32'sd5, 10, 1'b0);
    txn(2'b11, 32'd9, 32'd10, 32'd7, -32'sd3, 0, 1'b0);

    // Bypasses.
    txn(2'b01, 32'd5, 32'd0, 32'd0, 32'd0, 0, 1'b0);
    txn(2'b10, 32'd0, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);

    // Timeout, then a stray late completion, then normal service.
    hang = 1'b1;
    txn(2'b01, 32'd1000, 32'd3, 32'd0, 32'd0, 0, 1'b1);
    hang = 1'b0;
    inj_done = 1'b1;
    tick;
    inj_done = 1'b0;
    tick;
    chk("late_done_ignored", 64'({busy, rsp_valid}), 64'(0));
    txn(2'b01, 32'd1000, 32'd3, 32'd0, 32'd0, 0, 1'b0);

    // Randomized traffic with a bias toward the corner operands.
    for (int t = 0; t < 12; t++) begin
      rx0 = $urandom; rx1 = $urandom;
      ry0 = $urandom >> $urandom_range(0, 31);
      ry1 = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 5) == 0) ry0 = '0;
      if ($urandom_range(0, 5) == 0) begin rx1 = 32'h8000_0000; ry1 = '1; end
      if ($urandom_range(0, 3) == 0) ry1 = -ry1;
      txn(2'(int'($urandom_range(1, 3))), rx0, ry0, rx1, ry1,
          int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset while waiting on the core.
    req_x0 = 32'd50; req_y0 = 32'd5;
    req_valid = 2'b01;
    #1;
    tick;
    req_valid = 2'b00;
    repeat (5) tick;
    chk("in_wait_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", 64'({req_ready, rsp_valid, div_start, busy, rsp_err}), 64'(0));
    chk("mid_rst_data", {rsp_q, rsp_r}, 64'(0));
    chk("mid_rst_ops", {div_x, div_y}, 64'(0));
    tick;
    rst = 1'b0;
    last_grant_m = 1;
    inj_done = 1'b1;
    tick;
    inj_done = 1'b0;
    idle_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (busy || rsp_valid != 2'b00) idle_ok = 1'b0;
      tick;
    end
    chk("no_stale_rsp", 64'(idle_ok), 64'(1));
    txn(2'b11, 32'd50, 32'd5, 32'd60, 32'd7, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
